// File: rtl/ps2_pkg.sv
// Shared constants and the queued scan-code record for the PS/2 receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_code_t;

endpackage

// File: rtl/ps2_rx_fifo_frame_rx.sv
// PS/2 pin synchronisers, falling-edge detect, 11-bit framing,
// frame/parity checking and mid-frame timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int IW = $clog2(TIMEOUT);

  logic [1:0]    clk_s_q, dat_s_q;
  logic          clk_prev_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          err_parity_q, err_frame_q;
  logic          par_e, frm_e;
  logic          fall, last;

  always_comb begin
    fall       = clk_prev_q & ~clk_s_q[1];
    last       = cnt_q == 4'(PS2_FRAME_BITS - 1);
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    idle_d     = idle_q;
    byte_valid = 1'b0;
    par_e      = 1'b0;
    frm_e      = 1'b0;
    byte_data  = shift_q[8:1];
    if (fall) begin
      idle_d = '0;
      if (last) begin
        cnt_d = '0;
        // shift_q[0] is the start bit, the live data line is the stop bit
        if (shift_q[0] || !dat_s_q[1]) begin
          frm_e = 1'b1;
        end else if (!(^shift_q[9:1])) begin
          par_e = 1'b1;
        end else begin
          byte_valid = 1'b1;
        end
      end else begin
        cnt_d   = cnt_q + 4'd1;
        shift_d = {dat_s_q[1], shift_q[9:1]};
      end
    end else if (cnt_q != '0) begin
      if (idle_q == IW'(TIMEOUT - 1)) begin
        cnt_d  = '0;
        idle_d = '0;
        frm_e  = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s_q      <= '0;
      dat_s_q      <= '0;
      clk_prev_q   <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      idle_q       <= '0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      clk_s_q      <= {clk_s_q[0], ps2_clk};
      dat_s_q      <= {dat_s_q[0], ps2_data};
      clk_prev_q   <= clk_s_q[1];
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      err_parity_q <= par_e;
      err_frame_q  <= frm_e;
    end
  end

  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with ready/valid FIFO and sticky overflow.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into ext/brk flags.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 10000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     err_parity,
  output logic                     err_frame
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic       byte_valid;
  logic [7:0] byte_data;

  ps2_frame_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .err_parity(err_parity),
    .err_frame (err_frame)
  );

  ps2_code_t wcode;
  logic      push_req;

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_q, ext_d, brk_q, brk_d;

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    push_req   = 1'b0;
    wcode.ext  = ext_q;
    wcode.brk  = brk_q;
    wcode.code = byte_data;
    if (err_parity || err_frame) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      if (byte_data == PS2_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_data == PS2_PFX_BRK) begin
        brk_d = 1'b1;
      end else begin
        push_req = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end
`else
  always_comb begin
    push_req   = byte_valid;
    wcode.ext  = 1'b0;
    wcode.brk  = 1'b0;
    wcode.code = byte_data;
  end
`endif

  ps2_code_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  ps2_code_t     out_data_q, out_data_d;
  logic          pop, push, full;

  always_comb begin
    pop        = (count_q != '0) && out_ready;
    full       = count_q == CW'(DEPTH);
    // a pop in the same cycle frees the slot a full FIFO needs
    push       = push_req && (!full || pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (push_req && full && !pop) overflow_d = 1'b1;
    if (count_d == '0) begin
      out_data_d = '0;
    end else if (push && wr_ptr_q == rd_ptr_d) begin
      out_data_d = wcode;
    end else begin
      out_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= wcode;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = count_q != '0;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: framing, errors, timeout,
// overflow, prefix decode (either build) and async reset.
module tb_ps2_rx_fifo;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_valid;
  logic [9:0] out_data;
  logic [3:0] count;
  logic       overflow;
  logic       err_parity;
  logic       err_frame;

  int checks = 0;
  int failures = 0;
  int n_par = 0;
  int n_frm = 0;

  ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .err_parity(err_parity),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_parity) n_par <= n_par + 1;
    if (err_frame)  n_frm <= n_frm + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b,
                                          input bit flip_par,
                                          input bit bad_start);
    logic p;
    p = ~(^b) ^ flip_par;
    return {1'b1, p, b, bad_start};
  endfunction

  task automatic send_bit(input logic v);
    ps2_data = v;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mkframe(b, 1'b0, 1'b0), 11);
  endtask

  task automatic pop_expect(input string tag, input logic [9:0] e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(e));
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int p0, f0;

    tick(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_err", 32'({err_parity, err_frame}), 32'd0);
    rst = 1'b0;
    tick(5);

    // 0x1C with stop-bit latency measured from the pin edge
    send_bits(mkframe(8'h1C, 1'b0, 1'b0), 10);
    ps2_data = 1'b1;
    tick(10);
    ps2_clk = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick(1);
      lat++;
    end
    chk("lat_window", 32'(lat >= 2 && lat <= 4), 32'd1);
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
    chk("g1_count", 32'(count), 32'd1);
    pop_expect("g1", 10'h01C);
    chk("g1_empty", 32'(count), 32'd0);

    // parity flip then a good byte
    p0 = n_par; f0 = n_frm;
    send_bits(mkframe(8'h1C, 1'b1, 1'b0), 11);
    tick(3);
    chk("par_pulses", 32'(n_par - p0), 32'd1);
    chk("par_nofrm", 32'(n_frm - f0), 32'd0);
    chk("par_nopush", 32'(count), 32'd0);
    send_byte(8'h32);
    pop_expect("g2", 10'h032);

    // bad start and bad parity together: frame error only
    p0 = n_par; f0 = n_frm;
    send_bits(mkframe(8'h1C, 1'b1, 1'b1), 11);
    tick(3);
    chk("both_frm", 32'(n_frm - f0), 32'd1);
    chk("both_par", 32'(n_par - p0), 32'd0);
    chk("both_nopush", 32'(count), 32'd0);

    // partial frame abandoned by timeout
    f0 = n_frm;
    send_bits(mkframe(8'h55, 1'b0, 1'b0), 6);
    tick(TIMEOUT + 20);
    chk("to_frm", 32'(n_frm - f0), 32'd1);
    chk("to_nopush", 32'(count), 32'd0);
    send_byte(8'h1C);
    pop_expect("to_next", 10'h01C);

    // DEPTH+1 frames with no consumer
    for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i));
    chk("ov_count", 32'(count), 32'(DEPTH));
    chk("ov_flag", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("ov_order", 32'(out_data), 32'(8'h10 + 8'(i)));
      tick(1);
    end
    out_ready = 1'b0;
    chk("ov_drained", 32'(count), 32'd0);
    chk("ov_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ov_clr", 32'(overflow), 32'd0);

    // full FIFO with a pop in the push cycle
    for (int i = 0; i < DEPTH; i++) send_byte(8'h20 + 8'(i));
    send_bits(mkframe(8'h28, 1'b0, 1'b0), 10);
    ps2_data = 1'b1;
    tick(10);
    ps2_clk = 1'b0;
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(17);
    ps2_clk = 1'b1;
    tick(10);
    chk("pp_count", 32'(count), 32'(DEPTH));
    chk("pp_noovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("pp_order", 32'(out_data), 32'(8'h20 + 8'(i)));
      tick(1);
    end
    out_ready = 1'b0;
    chk("pp_drained", 32'(count), 32'd0);

`ifdef PS2_PREFIX_DECODE_EN
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("pf_brk_cnt", 32'(count), 32'd1);
    pop_expect("pf_brk", 10'h11C);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    chk("pf_eb_cnt", 32'(count), 32'd1);
    pop_expect("pf_eb", 10'h374);
    send_byte(8'hE0);
    send_bits(mkframe(8'h11, 1'b1, 1'b0), 11);
    send_byte(8'h74);
    chk("pf_clr_cnt", 32'(count), 32'd1);
    pop_expect("pf_clr", 10'h074);
`else
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("raw_cnt", 32'(count), 32'd2);
    pop_expect("raw_f0", 10'h0F0);
    pop_expect("raw_1c", 10'h01C);
`endif

    // async reset mid-frame with entries queued
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    chk("mr_queued", 32'(count), 32'd3);
    send_bits(mkframe(8'h44, 1'b0, 1'b0), 5);
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_err", 32'({err_parity, err_frame, overflow}), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);
    send_byte(8'h5A);
    chk("mr_next_cnt", 32'(count), 32'd1);
    pop_expect("mr_next", 10'h05A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
